decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
Registered, parametrised instruction-decode pipeline stage for the MIPS-subset core. It replaces the purely combinational decoder with a data-width-generic design that contains an internal register file with writeback bypass and a load-use interlock. The output pipeline register is held under a valid/ready handshake, supports flush, and maintains a stall performance counter. It sits between fetch and execute.

Parameters:
DATA_WIDTH, 32, datapath and register width; must be ≥ PC_HI_BITS+28 and ≥ 32.
REG_SEL_BITS, 5, register-select width; the file holds 2**REG_SEL_BITS registers.
PC_HI_BITS, 4, number of upper PC bits concatenated into jump targets.
CNT_WIDTH, 16, width of the stall counter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts this cycle
PC  in  PC_HI_BITS  upper PC bits of the fetched instruction
instruction  in  32  instruction word
flush  in  1  kill the held output and drop the input
ex_load_valid  in  1  execute stage holds an LW
ex_load_reg  in  REG_SEL_BITS  destination register of that LW
RF_write  in  1  writeback enable
RF_ws_reg  in  REG_SEL_BITS  writeback register
RF_write_data  in  DATA_WIDTH  writeback data
out_valid  out  1  registered decode result valid
out_ready  in  1  execute consumes the result
branch, write, logic_r_type, illegal  out  1 each  registered control bits
PCSource  out  3  0 = seq, 1 = J/JAL, 2 = JR/JALR, 3 = branch
ALU_Op  out  4  see Behaviour
ws_reg  out  REG_SEL_BITS  destination register
operand_A, operand_B, read2_data, targetReg, branchAddr, jumpAddr  out  DATA_WIDTH each  registered datapath values
stall_cycles  out  CNT_WIDTH  count of interlock cycles

Behaviour:
- Reset: out_valid = 0, all registered outputs = 0, stall_cycles = 0, all registers = 0.
- Register 0 always reads 0; writes to register 0 are ignored.
- Register file: writes on the clock edge when RF_write is high.
- Reads are combinational with bypass: if RF_write, RF_ws_reg == sel, and sel != 0, the read returns RF_write_data that same cycle.
- Immediate extension: sign-extended to DATA_WIDTH for LW, SW, ADDI, ADDIU, SLTI, SLTIU. Zero-extended for ANDI, ORI, XORI.
- shamt is zero-extended to DATA_WIDTH.
- branchAddr = sign-extended {imm, 2'b00}.
- jumpAddr = zero-extended {PC, instr[25:0], 2'b00}.
- ALU_Op encoding:
  - 0: LW, SW, ADD, ADDI, ADDIU, ADDU; also the default.
  - 1: AND/ANDI. 2: NOR. 3: OR/ORI. 4: SLL/SLLV. 5: SLT/SLTI/SLTIU/SLTU.
  - 6: SRA/SRAV. 7: SRL/SRLV. 8: SUB/SUBU. 9: XOR/XORI.
  - 10: BEQ. 11: BGEZ. 12: BGTZ. 13: BLEZ. 14: BLTZ. 15: BNE.
- operand_A = rt_data for SLL/SRA/SRL, otherwise rs_data.
- operand_B selection:
  - rt_data for register-register R-type and branches;
  - extended immediate for I-type;
  - shamt for SLL/SRA/SRL;
  - 0 otherwise.
- ws_reg = 31 for JAL/JALR; rd for R-type; rt otherwise.
- write = 1 for R-type, JAL, JALR and write-enabling I-type.
- targetReg = rs_data. logic_r_type = SLL|SRL|SRA.
- illegal = 1 for any encoding outside the subset; in that case write = 0, branch = 0, PCSource = 0.
- uses_rs: every decoded instruction except J, JAL, SLL, SRA, SRL.
- uses_rt: R-type, SW, BEQ, BNE.
- hazard = in_valid & ex_load_valid & (ex_load_reg != 0) & ((uses_rs & rs == ex_load_reg) | (uses_rt & rt == ex_load_reg)).
- in_ready = !flush & !hazard & (!out_valid | out_ready). The signal is combinational.
- Capture: when in_valid & in_ready, the decoded fields are registered and out_valid is set next cycle. Latency is 1 cycle.
- Hold: when out_valid & !out_ready, the outputs are held stable. Registered operands are not refreshed by a later writeback.
- Drain: when out_ready is high and nothing is captured, out_valid is cleared next cycle.
- Flush: out_valid = 0 next cycle, with priority over capture and hold. The input is not accepted; data regs are don't-care.
- stall_cycles: +1 on every cycle with hazard & !flush. It saturates at all-ones and does not wrap.
- A reset asserted mid-stall or mid-hold restores the reset state on the next edge. No partial result survives.

Test Plan:
- Reset, then ADDI r1,r0,-5 with out_ready = 1 → next cycle out_valid = 1, operand_B = 0xFFFFFFFB, ws_reg = 1, write = 1, ALU_Op = 0.
- Write-read bypass: RF_write r2 = 0x1234 in the same cycle as decoding ADD r3,r2,r2 → operand_A = operand_B = 0x1234.
- Write-read bypass on r0: RF_write r0 = 0x55 in the same cycle → register 0 still reads 0.
- Load-use: ex_load_valid = 1, ex_load_reg = 4, instruction SW r4,0(r5) held for 2 cycles → in_ready = 0 both cycles and stall_cycles = 2. With ex_load_reg = 0, ex_load_valid = 1 and the same instruction → no stall.
- Backpressure: out_ready = 0 for 3 cycles after a capture → outputs are held bit-stable and in_ready = 0. Raising out_ready accepts the next instruction in that cycle.
- Flush with out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle and in_ready = 0 during the flush cycle.
- ORI r1,r0,0x8000 → operand_B = 0x00008000. J 0x0000010 with PC = 0xA → jumpAddr = 0xA0000040, PCSource = 1. Opcode 0x3F → illegal = 1, write = 0.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// Registered MIPS-subset decode stage: register file with writeback bypass, load-use interlock,
// valid/ready output register with flush, and a saturating interlock-cycle counter.
module decode_pipe_stage #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_SEL_BITS = 5,
  parameter int unsigned PC_HI_BITS   = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_HI_BITS-1:0]   PC,
  input  logic [31:0]             instruction,
  input  logic                    flush,
  input  logic                    ex_load_valid,
  input  logic [REG_SEL_BITS-1:0] ex_load_reg,
  input  logic                    RF_write,
  input  logic [REG_SEL_BITS-1:0] RF_ws_reg,
  input  logic [DATA_WIDTH-1:0]   RF_write_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    branch,
  output logic                    write,
  output logic                    logic_r_type,
  output logic                    illegal,
  output logic [2:0]              PCSource,
  output logic [3:0]              ALU_Op,
  output logic [REG_SEL_BITS-1:0] ws_reg,
  output logic [DATA_WIDTH-1:0]   operand_A,
  output logic [DATA_WIDTH-1:0]   operand_B,
  output logic [DATA_WIDTH-1:0]   read2_data,
  output logic [DATA_WIDTH-1:0]   targetReg,
  output logic [DATA_WIDTH-1:0]   branchAddr,
  output logic [DATA_WIDTH-1:0]   jumpAddr,
  output logic [CNT_WIDTH-1:0]    stall_cycles
);

  localparam int unsigned NumRegs = 2 ** REG_SEL_BITS;

  typedef enum logic [1:0] {BSelZero, BSelRt, BSelImm, BSelShamt} b_sel_e;

  logic [DATA_WIDTH-1:0] r_rf [NumRegs];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  assign w_op    = instruction[31:26];
  assign w_rs    = instruction[25:21];
  assign w_rt    = instruction[20:16];
  assign w_rd    = instruction[15:11];
  assign w_shamt = instruction[10:6];
  assign w_funct = instruction[5:0];
  assign w_imm   = instruction[15:0];

  logic [REG_SEL_BITS-1:0] w_rs_sel, w_rt_sel;
  logic [DATA_WIDTH-1:0]   w_rs_data, w_rt_data;
  assign w_rs_sel = REG_SEL_BITS'(w_rs);
  assign w_rt_sel = REG_SEL_BITS'(w_rt);

  // Same-cycle writeback is forwarded so the decoded operands are never one write stale.
  always_comb begin
    w_rs_data = r_rf[w_rs_sel];
    w_rt_data = r_rf[w_rt_sel];
    if (RF_write && RF_ws_reg == w_rs_sel) w_rs_data = RF_write_data;
    if (RF_write && RF_ws_reg == w_rt_sel) w_rt_data = RF_write_data;
    if (w_rs_sel == '0) w_rs_data = '0;
    if (w_rt_sel == '0) w_rt_data = '0;
  end

  logic       w_illegal, w_branch, w_write, w_logic_r, w_sign_ext;
  logic       w_link, w_ws_rd, w_uses_rs, w_uses_rt;
  logic [2:0] w_pcsrc;
  logic [3:0] w_alu;
  b_sel_e     w_b_sel;

  always_comb begin
    w_illegal  = 1'b0;
    w_branch   = 1'b0;
    w_write    = 1'b0;
    w_logic_r  = 1'b0;
    w_sign_ext = 1'b1;
    w_link     = 1'b0;
    w_ws_rd    = 1'b0;
    w_uses_rs  = 1'b1;
    w_uses_rt  = 1'b0;
    w_pcsrc    = 3'd0;
    w_alu      = 4'd0;
    w_b_sel    = BSelZero;
    case (w_op)
      6'h00: begin
        w_ws_rd   = 1'b1;
        w_uses_rt = 1'b1;
        w_write   = 1'b1;
        w_b_sel   = BSelRt;
        case (w_funct)
          6'h00: begin w_alu = 4'd4; w_logic_r = 1'b1; end
          6'h02: begin w_alu = 4'd7; w_logic_r = 1'b1; end
          6'h03: begin w_alu = 4'd6; w_logic_r = 1'b1; end
          6'h04: w_alu = 4'd4;
          6'h06: w_alu = 4'd7;
          6'h07: w_alu = 4'd6;
          6'h08: begin w_write = 1'b0; w_pcsrc = 3'd2; end
          6'h09: begin w_link = 1'b1; w_pcsrc = 3'd2; end
          6'h20, 6'h21: w_alu = 4'd0;
          6'h22, 6'h23: w_alu = 4'd8;
          6'h24: w_alu = 4'd1;
          6'h25: w_alu = 4'd3;
          6'h26: w_alu = 4'd9;
          6'h27: w_alu = 4'd2;
          6'h2A, 6'h2B: w_alu = 4'd5;
          default: w_illegal = 1'b1;
        endcase
      end
      6'h01: begin
        w_branch = 1'b1;
        w_pcsrc  = 3'd3;
        w_b_sel  = BSelRt;
        case (w_rt)
          5'd0:    w_alu = 4'd14;
          5'd1:    w_alu = 4'd11;
          default: w_illegal = 1'b1;
        endcase
      end
      6'h02: begin w_pcsrc = 3'd1; w_uses_rs = 1'b0; end
      6'h03: begin w_pcsrc = 3'd1; w_uses_rs = 1'b0; w_write = 1'b1; w_link = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        w_branch  = 1'b1;
        w_pcsrc   = 3'd3;
        w_b_sel   = BSelRt;
        w_uses_rt = (w_op == 6'h04) || (w_op == 6'h05);
        w_alu     = (w_op == 6'h04) ? 4'd10 : (w_op == 6'h05) ? 4'd15 :
                    (w_op == 6'h06) ? 4'd13 : 4'd12;
      end
      6'h08, 6'h09, 6'h23: begin w_write = 1'b1; w_b_sel = BSelImm; end
      6'h0A, 6'h0B: begin w_write = 1'b1; w_b_sel = BSelImm; w_alu = 4'd5; end
      6'h0C: begin w_write = 1'b1; w_b_sel = BSelImm; w_sign_ext = 1'b0; w_alu = 4'd1; end
      6'h0D: begin w_write = 1'b1; w_b_sel = BSelImm; w_sign_ext = 1'b0; w_alu = 4'd3; end
      6'h0E: begin w_write = 1'b1; w_b_sel = BSelImm; w_sign_ext = 1'b0; w_alu = 4'd9; end
      6'h2B: begin w_b_sel = BSelImm; w_uses_rt = 1'b1; end
      default: w_illegal = 1'b1;
    endcase
    if (w_logic_r) begin
      w_uses_rs = 1'b0;
      w_b_sel   = BSelShamt;
    end
    // An unrecognised encoding must not write, redirect fetch, or cause an interlock.
    if (w_illegal) begin
      w_write   = 1'b0;
      w_branch  = 1'b0;
      w_pcsrc   = 3'd0;
      w_alu     = 4'd0;
      w_b_sel   = BSelZero;
      w_link    = 1'b0;
      w_ws_rd   = 1'b0;
      w_uses_rs = 1'b0;
      w_uses_rt = 1'b0;
      w_logic_r = 1'b0;
    end
  end

  logic [DATA_WIDTH-1:0]   w_imm_ext, w_opa, w_opb, w_baddr, w_jaddr;
  logic [REG_SEL_BITS-1:0] w_ws;

  assign w_imm_ext = w_sign_ext ? DATA_WIDTH'($signed(w_imm)) : DATA_WIDTH'(w_imm);
  assign w_baddr   = DATA_WIDTH'($signed({w_imm, 2'b00}));
  assign w_jaddr   = DATA_WIDTH'({PC, instruction[25:0], 2'b00});
  assign w_opa     = w_logic_r ? w_rt_data : w_rs_data;
  assign w_ws      = w_link ? REG_SEL_BITS'(5'd31) : w_ws_rd ? REG_SEL_BITS'(w_rd) : w_rt_sel;

  always_comb begin
    case (w_b_sel)
      BSelRt:    w_opb = w_rt_data;
      BSelImm:   w_opb = w_imm_ext;
      BSelShamt: w_opb = DATA_WIDTH'(w_shamt);
      default:   w_opb = '0;
    endcase
  end

  logic w_hazard, w_capture;
  assign w_hazard = in_valid && ex_load_valid && (ex_load_reg != '0) &&
                    ((w_uses_rs && (w_rs_sel == ex_load_reg)) ||
                     (w_uses_rt && (w_rt_sel == ex_load_reg)));
  assign in_ready  = !flush && !w_hazard && (!out_valid || out_ready);
  assign w_capture = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rf <= '{default: '0};
    end else if (RF_write && RF_ws_reg != '0) begin
      r_rf[RF_ws_reg] <= RF_write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      branch       <= 1'b0;
      write        <= 1'b0;
      logic_r_type <= 1'b0;
      illegal      <= 1'b0;
      PCSource     <= '0;
      ALU_Op       <= '0;
      ws_reg       <= '0;
      operand_A    <= '0;
      operand_B    <= '0;
      read2_data   <= '0;
      targetReg    <= '0;
      branchAddr   <= '0;
      jumpAddr     <= '0;
      stall_cycles <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (w_capture) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (w_capture) begin
        branch       <= w_branch;
        write        <= w_write;
        logic_r_type <= w_logic_r;
        illegal      <= w_illegal;
        PCSource     <= w_pcsrc;
        ALU_Op       <= w_alu;
        ws_reg       <= w_ws;
        operand_A    <= w_opa;
        operand_B    <= w_opb;
        read2_data   <= w_rt_data;
        targetReg    <= w_rs_data;
        branchAddr   <= w_baddr;
        jumpAddr     <= w_jaddr;
      end
      if (w_hazard && !flush && stall_cycles != {CNT_WIDTH{1'b1}}) begin
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed steps then random traffic, checked against a
// table-driven decode model with its own register file and handshake bookkeeping.
module tb_decode_pipe_stage;

  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset, in_valid, flush, ex_load_valid, RF_write, out_ready;
  logic [3:0]    PC;
  logic [31:0]   instruction, RF_write_data;
  logic [4:0]    ex_load_reg, RF_ws_reg;
  logic          in_ready, out_valid, branch, write, logic_r_type, illegal;
  logic [2:0]    PCSource;
  logic [3:0]    ALU_Op;
  logic [4:0]    ws_reg;
  logic [31:0]   operand_A, operand_B, read2_data, targetReg, branchAddr, jumpAddr;
  logic [CW-1:0] stall_cycles;

  always #5 clock = ~clock;

  decode_pipe_stage #(.DATA_WIDTH(32), .REG_SEL_BITS(5), .PC_HI_BITS(4), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .PC(PC),
    .instruction(instruction), .flush(flush), .ex_load_valid(ex_load_valid),
    .ex_load_reg(ex_load_reg), .RF_write(RF_write), .RF_ws_reg(RF_ws_reg),
    .RF_write_data(RF_write_data), .out_valid(out_valid), .out_ready(out_ready),
    .branch(branch), .write(write), .logic_r_type(logic_r_type), .illegal(illegal),
    .PCSource(PCSource), .ALU_Op(ALU_Op), .ws_reg(ws_reg), .operand_A(operand_A),
    .operand_B(operand_B), .read2_data(read2_data), .targetReg(targetReg),
    .branchAddr(branchAddr), .jumpAddr(jumpAddr), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic il, br, wr, lr;
    logic [2:0] pcsrc;
    logic [3:0] alu;
    logic [4:0] ws;
    logic [31:0] opa, opb, rd2, tgt, baddr, jaddr;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {illegal, branch, write, logic_r_type, PCSource, ALU_Op, ws_reg, operand_A,
                  operand_B, read2_data, targetReg, branchAddr, jumpAddr};

  // bsrc: 0 zero, 1 rt, 2 sign-ext imm, 3 zero-ext imm, 4 shamt
  typedef struct {
    logic [5:0] op, fn;
    logic [3:0] alu;
    int bsrc;
    logic [2:0] pcs;
    bit wr, link, drd, urs, urt, sh;
  } itab_t;
  itab_t tab[$];

  int checks = 0;
  int errors = 0;

  logic [31:0]   m_rf [32];
  bit            m_valid = 1'b0;
  outs_t         m_out;
  logic [CW-1:0] m_stall;

  function automatic void add(input int op, fn, alu, bsrc, pcs, wr, link, drd, urs, urt, sh);
    itab_t t;
    t.op = 6'(op); t.fn = 6'(fn); t.alu = 4'(alu); t.bsrc = bsrc; t.pcs = 3'(pcs);
    t.wr = wr[0]; t.link = link[0]; t.drd = drd[0]; t.urs = urs[0]; t.urt = urt[0];
    t.sh = sh[0];
    tab.push_back(t);
  endfunction

  function automatic void addr(input int fn, alu);
    add(0, fn, alu, 1, 0, 1, 0, 1, 1, 1, 0);
  endfunction

  function automatic void build_table();
    add(0, 'h00, 4, 4, 0, 1, 0, 1, 0, 1, 1);
    add(0, 'h02, 7, 4, 0, 1, 0, 1, 0, 1, 1);
    add(0, 'h03, 6, 4, 0, 1, 0, 1, 0, 1, 1);
    addr('h04, 4); addr('h06, 7); addr('h07, 6);
    add(0, 'h08, 0, 1, 2, 0, 0, 1, 1, 1, 0);
    add(0, 'h09, 0, 1, 2, 1, 1, 1, 1, 1, 0);
    addr('h20, 0); addr('h21, 0); addr('h22, 8); addr('h23, 8); addr('h24, 1);
    addr('h25, 3); addr('h26, 9); addr('h27, 2); addr('h2A, 5); addr('h2B, 5);
    add(1, 0, 14, 1, 3, 0, 0, 0, 1, 0, 0);
    add(1, 1, 11, 1, 3, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(4, 0, 10, 1, 3, 0, 0, 0, 1, 1, 0);
    add(5, 0, 15, 1, 3, 0, 0, 0, 1, 1, 0);
    add(6, 0, 13, 1, 3, 0, 0, 0, 1, 0, 0);
    add(7, 0, 12, 1, 3, 0, 0, 0, 1, 0, 0);
    add('h08, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0);
    add('h09, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0);
    add('h0A, 0, 5, 2, 0, 1, 0, 0, 1, 0, 0);
    add('h0B, 0, 5, 2, 0, 1, 0, 0, 1, 0, 0);
    add('h0C, 0, 1, 3, 0, 1, 0, 0, 1, 0, 0);
    add('h0D, 0, 3, 3, 0, 1, 0, 0, 1, 0, 0);
    add('h0E, 0, 9, 3, 0, 1, 0, 0, 1, 0, 0);
    add('h23, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0);
    add('h2B, 0, 0, 2, 0, 0, 0, 0, 1, 1, 0);
  endfunction

  function automatic int find(input logic [31:0] ins);
    foreach (tab[i]) begin
      if (tab[i].op == ins[31:26] &&
          (ins[31:26] > 6'd1 || (ins[31:26] == 6'd0 && tab[i].fn == ins[5:0]) ||
           (ins[31:26] == 6'd1 && tab[i].fn == {1'b0, ins[20:16]})))
        return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (RF_write && RF_ws_reg == s) return RF_write_data;
    return m_rf[s];
  endfunction

  function automatic outs_t mdec(input logic [31:0] ins, input logic [3:0] pc,
                                 output bit urs, output bit urt);
    outs_t o;
    int k;
    logic [31:0] rsd, rtd, sx;
    rsd = rdreg(ins[25:21]);
    rtd = rdreg(ins[20:16]);
    sx  = {{16{ins[15]}}, ins[15:0]};
    o = '0;
    o.il = 1'b1; o.ws = ins[20:16]; o.opa = rsd; o.rd2 = rtd; o.tgt = rsd;
    o.baddr = sx << 2; o.jaddr = {pc, ins[25:0], 2'b00};
    urs = 1'b0; urt = 1'b0;
    k = find(ins);
    if (k >= 0) begin
      o.il = 1'b0; o.alu = tab[k].alu; o.pcsrc = tab[k].pcs; o.wr = tab[k].wr;
      o.br = (tab[k].pcs == 3'd3); o.lr = tab[k].sh;
      if (tab[k].sh) o.opa = rtd;
      case (tab[k].bsrc)
        1: o.opb = rtd;
        2: o.opb = sx;
        3: o.opb = {16'h0, ins[15:0]};
        4: o.opb = {27'h0, ins[10:6]};
        default: o.opb = 32'd0;
      endcase
      if (tab[k].link) o.ws = 5'd31;
      else if (tab[k].drd) o.ws = ins[15:11];
      urs = tab[k].urs; urt = tab[k].urt;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [207:0] obs, input logic [207:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    outs_t d;
    bit urs, urt, hz, rdy, cap;
    @(negedge clock);
    d = mdec(instruction, PC, urs, urt);
    hz = in_valid && ex_load_valid && ex_load_reg != 5'd0 &&
         ((urs && instruction[25:21] == ex_load_reg) || (urt && instruction[20:16] == ex_load_reg));
    rdy = !flush && !hz && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    cap = in_valid && rdy;
    @(posedge clock);
    #1;
    if (reset) begin
      m_valid = 1'b0; m_out = '0; m_stall = '0;
      foreach (m_rf[i]) m_rf[i] = 32'd0;
    end else begin
      if (flush) m_valid = 1'b0;
      else if (cap) begin m_valid = 1'b1; m_out = d; end
      else if (out_ready) m_valid = 1'b0;
      if (hz && !flush && m_stall != '1) m_stall = m_stall + 1'b1;
      if (RF_write && RF_ws_reg != 5'd0) m_rf[RF_ws_reg] = RF_write_data;
    end
    chk("out_valid", out_valid, m_valid);
    chk("stall_cycles", stall_cycles, m_stall);
    if (m_valid) chk("outputs", dut_o, m_out);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) return w;
    k = $urandom_range(0, tab.size() - 1);
    w[31:26] = tab[k].op;
    if (tab[k].op == 6'd0) w[5:0] = tab[k].fn;
    else if (tab[k].op == 6'd1) w[20:16] = tab[k].fn[4:0];
    return w;
  endfunction

  initial begin
    int st0;
    build_table();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_load_valid = 1'b0; ex_load_reg = '0;
    RF_write = 1'b0; RF_ws_reg = '0; RF_write_data = '0; out_ready = 1'b1;
    PC = '0; instruction = '0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("rst_valid", out_valid, 0);
    chk("rst_outs", dut_o, 0);
    chk("rst_stall", stall_cycles, 0);

    in_valid = 1'b1; instruction = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFB);
    cycle();
    chk("addi_opb", operand_B, 32'hFFFF_FFFB);
    chk("addi_ws", ws_reg, 1);
    chk("addi_write", write, 1);
    chk("addi_alu", ALU_Op, 0);
    in_valid = 1'b0;
    cycle();

    in_valid = 1'b1; RF_write = 1'b1; RF_ws_reg = 5'd2; RF_write_data = 32'h1234;
    instruction = enc_r(5'd2, 5'd2, 5'd3, 5'd0, 6'h20);
    cycle();
    chk("byp_opa", operand_A, 32'h1234);
    chk("byp_opb", operand_B, 32'h1234);
    RF_ws_reg = 5'd0; RF_write_data = 32'h55; instruction = enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h20);
    cycle();
    chk("byp_r0_opa", operand_A, 0);
    chk("byp_r0_opb", operand_B, 0);
    RF_write = 1'b0;

    st0 = int'(m_stall);
    instruction = enc_i(6'h2B, 5'd5, 5'd4, 16'h0); ex_load_valid = 1'b1; ex_load_reg = 5'd4;
    cycle();
    chk("lu_rdy1", in_ready, 0);
    cycle();
    chk("lu_rdy2", in_ready, 0);
    chk("lu_stall", stall_cycles, st0 + 2);
    ex_load_reg = 5'd0;
    cycle();
    chk("lu_r0_stall", stall_cycles, st0 + 2);
    chk("lu_r0_valid", out_valid, 1);
    ex_load_valid = 1'b0;

    instruction = enc_r(5'd1, 5'd3, 5'd6, 5'd0, 6'h22);
    cycle();
    out_ready = 1'b0; instruction = enc_r(5'd1, 5'd1, 5'd7, 5'd0, 6'h20);
    RF_write = 1'b1; RF_ws_reg = 5'd1; RF_write_data = 32'hDEAD_BEEF;
    repeat (3) begin
      cycle();
      chk("bp_rdy", in_ready, 0);
    end
    RF_write = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_accept_opa", operand_A, 32'hDEAD_BEEF);

    flush = 1'b1;
    cycle();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0;

    instruction = enc_i(6'h0D, 5'd0, 5'd1, 16'h8000);
    cycle();
    chk("ori_opb", operand_B, 32'h0000_8000);
    PC = 4'hA; instruction = {6'h02, 26'h000_0010};
    cycle();
    chk("j_addr", jumpAddr, 32'hA000_0040);
    chk("j_pcsrc", PCSource, 1);
    instruction = {6'h3F, 26'h123_4567};
    cycle();
    chk("ill_flag", illegal, 1);
    chk("ill_write", write, 0);

    instruction = enc_i(6'h23, 5'd4, 5'd9, 16'h0); ex_load_valid = 1'b1; ex_load_reg = 5'd4;
    repeat (40) cycle();
    chk("stall_sat", stall_cycles, 31);
    ex_load_valid = 1'b0;

    instruction = enc_r(5'd7, 5'd7, 5'd8, 5'd0, 6'h25);
    cycle();
    out_ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_outs", dut_o, 0);
    chk("rst_hold_stall", stall_cycles, 0);

    repeat (600) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instruction = rand_instr();
      PC = 4'($urandom);
      ex_load_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: ex_load_reg = instruction[25:21];
        1: ex_load_reg = instruction[20:16];
        default: ex_load_reg = 5'($urandom_range(0, 7));
      endcase
      RF_write = ($urandom_range(0, 1) == 0);
      RF_ws_reg = 5'($urandom_range(0, 7));
      RF_write_data = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
